// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: set-2 scan-code sequencer; byte_in/byte_valid/frame_err/clear in -> j1_dir/j1_drop/j2_dir/j2_drop/seq_abort out
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYC = 2000000,
  parameter int CNT_W = 21
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       frame_err,
  input  logic       clear,
  output logic [3:0] j1_dir,
  output logic       j1_drop,
  output logic [3:0] j2_dir,
  output logic       j2_drop,
  output logic       seq_abort
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  state_t state, nxt;
  logic [CNT_W-1:0] cnt;
  logic is_pre, ev_v, ev_make, ev_ext;
  logic [1:0][2:0] key;
  logic [1:0] hit;
  assign is_pre = (state == IDLE || state == EXT) && (byte_in == 8'hE0 || byte_in == 8'hF0);
  assign ev_v = byte_valid && !clear && !frame_err && !is_pre;
  assign ev_make = state == IDLE || state == EXT;
  assign ev_ext = state == EXT || state == EXT_BRK;
  assign nxt = (byte_in == 8'hF0 && state == IDLE) ? BRK :
               (byte_in == 8'hF0 && state == EXT) ? EXT_BRK :
               (byte_in == 8'hE0 && (state == IDLE || state == EXT)) ? EXT : IDLE;
  assign key[0] = byte_in == 8'h1D ? 3'd0 : byte_in == 8'h1B ? 3'd1 : byte_in == 8'h1C ? 3'd2 :
                  byte_in == 8'h23 ? 3'd3 : byte_in == 8'h29 ? 3'd4 : 3'd7;
  assign key[1] = byte_in == 8'h5A ? 3'd4 : !ev_ext ? 3'd7 : byte_in == 8'h75 ? 3'd0 :
                  byte_in == 8'h72 ? 3'd1 : byte_in == 8'h6B ? 3'd2 : byte_in == 8'h74 ? 3'd3 : 3'd7;
  assign hit[0] = ev_v && !ev_ext && key[0] != 3'd7;
  assign hit[1] = ev_v && key[1] != 3'd7;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      seq_abort <= 1'b0;
    end else begin
      seq_abort <= 1'b0;
      if (clear) begin
        state <= IDLE;
        cnt <= '0;
      end else if (frame_err) begin
        state <= IDLE;
        cnt <= '0;
        seq_abort <= state != IDLE;
      end else if (byte_valid) begin
        state <= nxt;
        cnt <= '0;
      end else if (state != IDLE && cnt == CNT_LAST) begin
        state <= IDLE;
        cnt <= '0;
        seq_abort <= 1'b1;
      end else begin
        cnt <= state == IDLE ? '0 : cnt + 1'b1;
      end
    end
  end
  function automatic logic [3:0] arb(input logic [3:0] h, input logic [1:0] l, input logic lv);
    return (lv && h[l]) ? 4'b0001 << l : h[0] ? 4'b0001 : h[1] ? 4'b0010 : h[2] ? 4'b0100 : h[3] ? 4'b1000 : 4'b0000;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : g_pl
    logic [3:0] held, dir_q;
    logic [1:0] last;
    logic last_v, dheld, dp, drop_q;
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        held <= '0;
        last <= '0;
        last_v <= 1'b0;
        dheld <= 1'b0;
        dp <= 1'b0;
        dir_q <= '0;
        drop_q <= 1'b0;
      end else begin
        dir_q <= arb(held, last, last_v);
        drop_q <= dp;
        dp <= 1'b0;
        if (clear) begin
          held <= '0;
          last_v <= 1'b0;
          dheld <= 1'b0;
        end else if (hit[g]) begin
          if (key[g] == 3'd4) begin
            dheld <= ev_make;
            dp <= ev_make && !dheld;
          end else if (!ev_make) begin
            held[key[g][1:0]] <= 1'b0;
          end else if (!held[key[g][1:0]]) begin
            held[key[g][1:0]] <= 1'b1;
            last <= key[g][1:0];
            last_v <= 1'b1;
          end
        end
      end
    end
  end
  assign j1_dir = g_pl[0].dir_q;
  assign j2_dir = g_pl[1].dir_q;
  assign j1_drop = g_pl[0].drop_q;
  assign j2_drop = g_pl[1].drop_q;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: scoreboard bench for ps2_key_ctrl with directed scan-code vectors
module tb_ps2_key_ctrl;
  localparam int T = 40;
  logic clk = 0, reset_n = 0, byte_valid = 0, frame_err = 0, clear = 0;
  logic [7:0] byte_in = 0;
  logic [3:0] j1_dir, j2_dir;
  logic j1_drop, j2_drop, seq_abort;
  int cyc = 0, vectors = 0, miss = 0, k;
  logic mon_en = 0;
  logic [3:0] p1 = 0, p2 = 0;
  typedef struct {int kind; logic [3:0] val; int cyc;} ev_t;
  ev_t q[$];
  ps2_key_ctrl #(.TIMEOUT_CYC(T), .CNT_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .frame_err(frame_err), .clear(clear), .j1_dir(j1_dir), .j1_drop(j1_drop),
    .j2_dir(j2_dir), .j2_drop(j2_drop), .seq_abort(seq_abort)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input int kind, input logic [3:0] v);
    ev_t e;
    vectors++;
    if (q.size() == 0) begin
      miss++;
      $display("FAIL unexpected kind=%0d val=%b at cyc %0d (no event required)", kind, v, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != v || e.cyc != cyc) begin
        miss++;
        $display("FAIL event got kind=%0d val=%b cyc=%0d, need kind=%0d val=%b cyc=%0d", kind, v, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (j1_dir != p1) chk(0, j1_dir);
    if (j2_dir != p2) chk(1, j2_dir);
    if (j1_drop) chk(2, 4'd1);
    if (j2_drop) chk(3, 4'd1);
    if (seq_abort) chk(4, 4'd1);
    p1 = j1_dir;
    p2 = j2_dir;
  end
  task automatic exp(input int kind, input logic [3:0] v, input int c);
    q.push_back('{kind, v, c});
  endtask
  task automatic send(input logic [7:0] b, input logic fe, input logic clr, output int kk);
    byte_in = b;
    byte_valid = 1;
    frame_err = fe;
    clear = clr;
    kk = cyc;
    @(posedge clk);
    #1;
    byte_valid = 0;
    frame_err = 0;
    clear = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    ev_t e;
    idle(3);
    reset_n = 1;
    idle(1);
    vectors++;
    if ({j1_dir, j2_dir, j1_drop, j2_drop, seq_abort} != 0) begin
      miss++;
      $display("FAIL reset outputs got %b need 0", {j1_dir, j2_dir, j1_drop, j2_drop, seq_abort});
    end
    mon_en = 1;
    send(8'h1D, 0, 0, k); exp(0, 4'b0001, k + 2); idle(9);
    send(8'hF0, 0, 0, k); idle(9);
    send(8'h1D, 0, 0, k); exp(0, 4'b0000, k + 2); idle(9);
    send(8'hE0, 0, 0, k); send(8'h75, 0, 0, k); exp(1, 4'b0001, k + 2); idle(5);
    send(8'hE0, 0, 0, k); send(8'h6B, 0, 0, k); exp(1, 4'b0100, k + 2); idle(5);
    send(8'hE0, 0, 0, k); send(8'hF0, 0, 0, k); send(8'h6B, 0, 0, k); exp(1, 4'b0001, k + 2); idle(5);
    send(8'h29, 0, 0, k); exp(2, 4'd1, k + 2); idle(4);
    send(8'h29, 0, 0, k); idle(4);
    send(8'h29, 0, 0, k); idle(4);
    send(8'hF0, 0, 0, k); send(8'h29, 0, 0, k); idle(4);
    send(8'h29, 0, 0, k); exp(2, 4'd1, k + 2); idle(5);
    send(8'hE0, 0, 0, k); exp(4, 4'd1, k + T + 1); idle(T + 20);
    send(8'h75, 0, 0, k); idle(5);
    send(8'hE0, 0, 0, k); idle(2);
    frame_err = 1; k = cyc; exp(4, 4'd1, k + 1); @(posedge clk); #1 frame_err = 0; idle(3);
    send(8'h75, 0, 0, k); idle(5);
    send(8'h1D, 0, 0, k); exp(0, 4'b0001, k + 2); idle(4);
    send(8'h1C, 0, 0, k); exp(0, 4'b0100, k + 2); idle(4);
    send(8'hE0, 0, 0, k); send(8'h74, 0, 0, k); exp(1, 4'b1000, k + 2); idle(4);
    send(8'h23, 0, 1, k); exp(0, 4'b0000, k + 2); exp(1, 4'b0000, k + 2); idle(8);
    send(8'hF0, 1, 0, k); send(8'h1B, 0, 0, k); exp(0, 4'b0010, k + 2); idle(4);
    send(8'h1D, 0, 0, k); exp(0, 4'b0001, k + 2); idle(4);
    send(8'hF0, 0, 0, k); send(8'h1D, 0, 0, k); exp(0, 4'b0010, k + 2); idle(10);
    mon_en = 0;
    while (q.size() != 0) begin
      e = q.pop_front();
      vectors++;
      miss++;
      $display("FAIL missing kind=%0d got none need val=%b at cyc %0d", e.kind, e.val, e.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
Scan-code sequencer between the PS/2 byte receiver and the game logic. Consumes validated set-2 bytes and runs the E0/F0 prefix state machine to produce make/break events. Keeps a held-key map per player and arbitrates each player's held directions down to a single one-hot movement command. Generates one-cycle bomb-drop pulses that ignore typematic repeat.

Parameters:
TIMEOUT_CYC, 2000000, idle cycles allowed inside a prefix sequence before the FSM aborts to IDLE (80 ms at 25 MHz)
CNT_W, 21, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  synchronous active-low reset, sampled on rising clk
byte_in  in  8  received scan-code byte
byte_valid  in  1  one-cycle strobe; byte_in is valid in this cycle
frame_err  in  1  one-cycle strobe; receiver saw a bad start, stop or parity bit
clear  in  1  force all keys released (game restart)
j1_dir  out  4  player 1 one-hot direction {right,left,down,up}; 0 = stand still
j1_drop  out  1  player 1 drop pulse
j2_dir  out  4  player 2 one-hot direction
j2_drop  out  1  player 2 drop pulse
seq_abort  out  1  one-cycle pulse when a prefix sequence is aborted by timeout or frame_err

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FSM goes to IDLE; held maps, last-pressed registers and timeout counter are cleared.
  - All outputs are 0.
- Key map (set 2, "E0" = extended):
  - P1: up 1D, down 1B, left 1C, right 23, drop 29.
  - P2: up E0 75, down E0 72, left E0 6B, right E0 74, drop 5A.
  - P2 drop 5A matches with or without E0.
  - A P2 arrow code without E0 is keypad and is unmapped.
  - Every other code (AA, FA, FE, EE, E1, ...) is unmapped and produces no event.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions happen only on a byte_valid cycle.
  - IDLE: E0 -> EXT; F0 -> BRK; any other byte -> make(code, ext=0), stay in IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte -> make(code, ext=1), go to IDLE.
  - BRK: any byte -> break(code, 0), go to IDLE.
  - EXT_BRK: any byte -> break(code, 1), go to IDLE.
- Timeout:
  - The counter clears on every byte_valid and whenever the FSM is in IDLE.
  - It increments each cycle while the FSM is not in IDLE.
  - When it reaches TIMEOUT_CYC-1, the FSM goes to IDLE and seq_abort pulses.
- frame_err:
  - The FSM goes to IDLE and any byte in the same cycle is discarded.
  - seq_abort pulses only if the FSM was not already in IDLE.
- Held map and last-pressed (per player: held[3:0], last[1:0], last_v):
  - make of a direction that is not held: set held, last = that direction, last_v = 1.
  - make of a direction that is already held (typematic repeat): no change.
  - break: clear held for that direction. last is left unchanged.
- Drop keys (held bit per player):
  - make while not held: set held and pulse drop for one cycle.
  - repeat make while held: no pulse.
  - break: clear held.
- Direction arbitration (per player):
  - If last_v and held[last]: dir = one-hot(last).
  - Otherwise dir = highest-priority held key, priority up > down > left > right.
  - Otherwise dir = 0.
- Latency:
  - Byte accepted in cycle k updates held/last at the edge ending cycle k.
  - The registered outputs reflect the change from cycle k+2.
  - A drop pulse is high for exactly cycle k+2.
- clear:
  - Empties all held maps, clears last_v and returns the FSM to IDLE.
  - The dir outputs are 0 from the second cycle after clear is asserted.
  - If clear and byte_valid occur in the same cycle, clear wins and the byte is discarded.
- A player may have opposite directions held (up+down); arbitration still yields exactly one bit.
- The two players' states are fully independent.

Test Plan:
- Reset, then bytes 1D; then F0 1D, spaced 10 cycles apart -> j1_dir=0001 from 2 cycles after 1D; j1_dir=0000 2 cycles after the final 1D; j2_dir stays 0.
- E0 75, then E0 6B, then E0 F0 6B -> j2_dir goes 0001, then 0100, then back to 0001 (last released, fallback to held up).
- Bytes 29 29 29 (typematic), then F0 29, then 29 -> exactly 2 j1_drop pulses, each one cycle wide, each 2 cycles after its accepted make byte.
- Byte E0, then 2000000 idle cycles -> seq_abort pulses once and the FSM is in IDLE; a following 75 (no E0) -> j2_dir stays 0 (keypad code, unmapped).
- Held 1D+1C+E0 74, then clear in the same cycle as byte 23 valid -> all dir outputs 0 two cycles later; the 23 is ignored (j1_dir stays 0).
- Byte F0 with frame_err in the same cycle, then 1B -> 1B is treated as a make, giving j1_dir=0010; seq_abort does not pulse (FSM was in IDLE).
